uart_mem_ctrl: RTL and testbench
================================

Name: uart_mem_ctrl

Overview:
Command-framed UART loader/debugger controller; successor to the fixed byte-stream loader control path, with a generalised word width and variable address/length framing. It sits between uart_rx/uart_tx and the CPU memories. It decodes host commands (write IMEM, read DMEM, run, halt) and packs or unpacks bytes to and from WORD_BYTES-wide words. It owns cpu_rst and the memory-mux select lines.

Parameters:
WORD_BYTES, 4, bytes per memory word; power of two, 1..8
IMEM_BYTE_ADDR_WIDTH, 6, IMEM byte-address width
DMEM_BYTE_ADDR_WIDTH, 6, DMEM byte-address width
WB_LOG2, derived, log2(WORD_BYTES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  received byte
rx_ready  in  1  one-cycle pulse: rx_data valid
tx_data  out  8  byte to transmit
tx_req  out  1  one-cycle transmit request
tx_empty  in  1  transmitter idle
cpu_rst  out  1  CPU held in reset when 1
imem_ctrl  out  1  1 = IMEM port owned by this block
imem_wr_en  out  1  IMEM write strobe
imem_addr  out  IMEM_BYTE_ADDR_WIDTH-WB_LOG2  IMEM word address
imem_byte_en  out  WORD_BYTES  one-hot lane enable
imem_wr_data  out  8*WORD_BYTES  byte replicated on all lanes
dmem_ctrl  out  1  1 = DMEM port owned by this block
dmem_rd_en  out  1  DMEM read strobe
dmem_addr  out  DMEM_BYTE_ADDR_WIDTH-WB_LOG2  DMEM word address
dmem_rd_data  in  8*WORD_BYTES  DMEM read word, valid 1 cycle after dmem_rd_en

Behaviour:
- Reset (rst=0, async): cpu_rst=1, imem_ctrl=1, dmem_ctrl=1. All strobes (tx_req, imem_wr_en, dmem_rd_en) are 0. tx_data=0, addresses=0, state=IDLE, running=0.
- Frame format: CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, then payload (write only).
  - CMD values: 0x01 write IMEM, 0x02 read DMEM, 0x03 run, 0x04 halt.
  - Address is truncated to the target memory's byte-address width.
  - LEN is 16 bits, counted in bytes.
- ACK=0x06, NAK=0x15.
- States: IDLE, HDR (4-byte counter), WRITE, RD_REQ, RD_WAIT, TX_WAIT, TX_HOLD.
- IDLE behaviour:
  - 0x03: cpu_rst, imem_ctrl and dmem_ctrl go to 0 on the next cycle; running=1; send ACK.
  - 0x04: all three go to 1 on the next cycle; running=0; send ACK.
  - 0x01 or 0x02 while running=1, or any unknown CMD: send NAK, return to IDLE, no memory access.
  - 0x01 or 0x02 with running=0: go to HDR.
- WRITE:
  - Each rx_ready causes imem_wr_en=1 for exactly one cycle, on the following cycle.
  - imem_addr = byte_addr[MSBs]; imem_byte_en = 1<<byte_addr[WB_LOG2-1:0].
  - byte_addr increments modulo 2^IMEM_BYTE_ADDR_WIDTH (wraps silently). LEN decrements.
  - When LEN reaches 0, send ACK. LEN=0 in the header sends ACK immediately.
- READ (per byte):
  - RD_REQ: dmem_rd_en=1 for 1 cycle.
  - RD_WAIT: latch the lane selected by byte_addr[WB_LOG2-1:0].
  - TX_WAIT: when tx_empty=1, present tx_data and pulse tx_req for 1 cycle.
  - TX_HOLD: ignore tx_empty for 1 cycle.
  - Then increment the address (DMEM wrap) and decrement LEN.
  - No ACK trails read data. LEN=0 returns to IDLE with no output.
- Every transmitted byte, including ACK and NAK, uses the TX_WAIT/TX_HOLD handshake.
- rx_ready outside IDLE/HDR/WRITE is ignored: the byte is dropped and no state change occurs.
- rst asserted mid-frame: immediate return to reset values; a partial write leaves already-written bytes in memory.

Optional Feature:
UART_MEM_CKSUM_EN
- Defined:
  - Write frames carry one trailing byte equal to the 8-bit sum of the payload.
  - On match send ACK; on mismatch send NAK. Payload writes are still performed.
  - Read replies append one 8-bit sum byte after the data.
- Undefined: no checksum bytes in either direction; logic is absent.

Test Plan:
- Write 01 04 00 04 00 AA BB CC DD (WORD_BYTES=4) -> 4 imem_wr_en pulses at imem_addr=1, byte_en 0001/0010/0100/1000, wr_data AAAAAAAA..DDDDDDDD; then tx 0x06.
- DMEM word1=0x44332211; send 02 05 00 02 00 -> two dmem_rd_en pulses at dmem_addr=1; tx 0x22, 0x33; no trailing byte.
- Send 03 -> cpu_rst, imem_ctrl, dmem_ctrl =0 and tx 0x06. Then 01 00 00 01 00 -> tx 0x15, no imem_wr_en. Then 04 -> all =1 and tx 0x06.
- Wrap: write 01 3F 00 02 00 11 22 -> writes at byte addr 63 (word 15, byte_en 1000), then byte addr 0 (word 0, byte_en 0001); tx 0x06.
- Hold tx_empty=0 for 50 cycles during a read -> tx_req stays 0 until tx_empty=1, then exactly one pulse. Unknown CMD 0x7F -> tx 0x15.
- rst=0 after the 2nd payload byte of a 4-byte write -> outputs return to reset values asynchronously. A new full frame afterwards completes with ACK.

Source files
------------

// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl: command-framed UART loader/debugger. Decodes host frames
// (CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, payload) to write IMEM, read DMEM,
// run or halt the CPU. Bytes are packed into / unpacked from WORD_BYTES-wide
// words. Owns cpu_rst and the IMEM/DMEM mux selects.
// Optional feature macro: UART_MEM_CKSUM_EN (8-bit additive checksum trailing
// write payloads and read replies).
// Ports:
//   clk, rst (async, active-low)
//   rx_data/rx_ready          : received byte stream from uart_rx
//   tx_data/tx_req/tx_empty   : byte transmit handshake to uart_tx
//   cpu_rst                   : CPU held in reset when 1
//   imem_ctrl, imem_wr_en, imem_addr, imem_byte_en, imem_wr_data : IMEM write port
//   dmem_ctrl, dmem_rd_en, dmem_addr, dmem_rd_data              : DMEM read port
module uart_mem_ctrl #(
    parameter int unsigned WORD_BYTES           = 4,
    parameter int unsigned IMEM_BYTE_ADDR_WIDTH = 6,
    parameter int unsigned DMEM_BYTE_ADDR_WIDTH = 6,
    localparam int unsigned WB_LOG2     = $clog2(WORD_BYTES),
    localparam int unsigned IMEM_WORD_W = IMEM_BYTE_ADDR_WIDTH - WB_LOG2,
    localparam int unsigned DMEM_WORD_W = DMEM_BYTE_ADDR_WIDTH - WB_LOG2,
    localparam int unsigned DATA_W      = 8 * WORD_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_req,
    input  logic                   tx_empty,
    output logic                   cpu_rst,
    output logic                   imem_ctrl,
    output logic                   imem_wr_en,
    output logic [IMEM_WORD_W-1:0] imem_addr,
    output logic [WORD_BYTES-1:0]  imem_byte_en,
    output logic [DATA_W-1:0]      imem_wr_data,
    output logic                   dmem_ctrl,
    output logic                   dmem_rd_en,
    output logic [DMEM_WORD_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0]      dmem_rd_data
);

    localparam int unsigned AW     = (IMEM_BYTE_ADDR_WIDTH > DMEM_BYTE_ADDR_WIDTH) ?
                                     IMEM_BYTE_ADDR_WIDTH : DMEM_BYTE_ADDR_WIDTH;
    localparam int unsigned LANE_W = (WB_LOG2 > 0) ? WB_LOG2 : 1;

    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;
    localparam logic [7:0] CMD_RUN  = 8'h03;
    localparam logic [7:0] CMD_HALT = 8'h04;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WRITE, S_RD_REQ, S_RD_WAIT, S_TX_WAIT, S_TX_HOLD
    } state_t;

    state_t                 state, state_nxt;
    logic [1:0]             hdr_cnt, hdr_cnt_nxt;
    logic                   is_wr, is_wr_nxt;
    logic [AW-1:0]          byte_addr, byte_addr_nxt;
    logic [15:0]            len, len_nxt;
    logic [7:0]             tx_byte, tx_byte_nxt;
    logic                   rd_active, rd_active_nxt;
    logic                   running, running_nxt;
`ifdef UART_MEM_CKSUM_EN
    logic [7:0]             sum, sum_nxt;
`endif

    logic [7:0]             tx_data_nxt;
    logic                   tx_req_nxt;
    logic                   cpu_rst_nxt, imem_ctrl_nxt, dmem_ctrl_nxt;
    logic                   imem_wr_en_nxt;
    logic [IMEM_WORD_W-1:0] imem_addr_nxt;
    logic [WORD_BYTES-1:0]  imem_byte_en_nxt;
    logic [DATA_W-1:0]      imem_wr_data_nxt;
    logic                   dmem_rd_en_nxt;
    logic [DMEM_WORD_W-1:0] dmem_addr_nxt;

    logic [LANE_W-1:0]               lane;
    logic [7:0]                      rd_byte;
    logic [IMEM_BYTE_ADDR_WIDTH-1:0] imem_inc;
    logic [DMEM_BYTE_ADDR_WIDTH-1:0] dmem_inc;
    logic [15:0]                     hdr_len;

    // Byte lane within the word, selected lane of the read word, wrapped increments
    assign lane     = LANE_W'(byte_addr & AW'(WORD_BYTES - 1));
    assign rd_byte  = dmem_rd_data[{lane, 3'b000} +: 8];
    assign imem_inc = byte_addr[IMEM_BYTE_ADDR_WIDTH-1:0] + IMEM_BYTE_ADDR_WIDTH'(1);
    assign dmem_inc = byte_addr[DMEM_BYTE_ADDR_WIDTH-1:0] + DMEM_BYTE_ADDR_WIDTH'(1);
    assign hdr_len  = {rx_data, len[7:0]};

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            hdr_cnt      <= '0;
            is_wr        <= 1'b0;
            byte_addr    <= '0;
            len          <= '0;
            tx_byte      <= '0;
            rd_active    <= 1'b0;
            running      <= 1'b0;
`ifdef UART_MEM_CKSUM_EN
            sum          <= '0;
`endif
            tx_data      <= '0;
            tx_req       <= 1'b0;
            cpu_rst      <= 1'b1;
            imem_ctrl    <= 1'b1;
            dmem_ctrl    <= 1'b1;
            imem_wr_en   <= 1'b0;
            imem_addr    <= '0;
            imem_byte_en <= '0;
            imem_wr_data <= '0;
            dmem_rd_en   <= 1'b0;
            dmem_addr    <= '0;
        end else begin
            state        <= state_nxt;
            hdr_cnt      <= hdr_cnt_nxt;
            is_wr        <= is_wr_nxt;
            byte_addr    <= byte_addr_nxt;
            len          <= len_nxt;
            tx_byte      <= tx_byte_nxt;
            rd_active    <= rd_active_nxt;
            running      <= running_nxt;
`ifdef UART_MEM_CKSUM_EN
            sum          <= sum_nxt;
`endif
            tx_data      <= tx_data_nxt;
            tx_req       <= tx_req_nxt;
            cpu_rst      <= cpu_rst_nxt;
            imem_ctrl    <= imem_ctrl_nxt;
            dmem_ctrl    <= dmem_ctrl_nxt;
            imem_wr_en   <= imem_wr_en_nxt;
            imem_addr    <= imem_addr_nxt;
            imem_byte_en <= imem_byte_en_nxt;
            imem_wr_data <= imem_wr_data_nxt;
            dmem_rd_en   <= dmem_rd_en_nxt;
            dmem_addr    <= dmem_addr_nxt;
        end
    end

    // Frame decoder, memory sequencing and transmit handshake
    always_comb begin
        state_nxt        = state;
        hdr_cnt_nxt      = hdr_cnt;
        is_wr_nxt        = is_wr;
        byte_addr_nxt    = byte_addr;
        len_nxt          = len;
        tx_byte_nxt      = tx_byte;
        rd_active_nxt    = rd_active;
        running_nxt      = running;
`ifdef UART_MEM_CKSUM_EN
        sum_nxt          = sum;
`endif
        tx_data_nxt      = tx_data;
        tx_req_nxt       = 1'b0;
        cpu_rst_nxt      = cpu_rst;
        imem_ctrl_nxt    = imem_ctrl;
        dmem_ctrl_nxt    = dmem_ctrl;
        imem_wr_en_nxt   = 1'b0;
        imem_addr_nxt    = imem_addr;
        imem_byte_en_nxt = imem_byte_en;
        imem_wr_data_nxt = imem_wr_data;
        dmem_rd_en_nxt   = 1'b0;
        dmem_addr_nxt    = dmem_addr;

        case (state)
            S_IDLE: begin
                if (rx_ready) begin
                    rd_active_nxt = 1'b0;
                    state_nxt     = S_TX_WAIT;
                    case (rx_data)
                        CMD_WR, CMD_RD: begin
                            // Memory commands are refused while the CPU owns the memories
                            if (running) begin
                                tx_byte_nxt = NAK;
                            end else begin
                                is_wr_nxt     = (rx_data == CMD_WR);
                                hdr_cnt_nxt   = '0;
                                byte_addr_nxt = '0;
                                len_nxt       = '0;
`ifdef UART_MEM_CKSUM_EN
                                sum_nxt       = '0;
`endif
                                state_nxt     = S_HDR;
                            end
                        end
                        CMD_RUN: begin
                            cpu_rst_nxt   = 1'b0;
                            imem_ctrl_nxt = 1'b0;
                            dmem_ctrl_nxt = 1'b0;
                            running_nxt   = 1'b1;
                            tx_byte_nxt   = ACK;
                        end
                        CMD_HALT: begin
                            cpu_rst_nxt   = 1'b1;
                            imem_ctrl_nxt = 1'b1;
                            dmem_ctrl_nxt = 1'b1;
                            running_nxt   = 1'b0;
                            tx_byte_nxt   = ACK;
                        end
                        default: tx_byte_nxt = NAK;
                    endcase
                end
            end

            S_HDR: begin
                if (rx_ready) begin
                    hdr_cnt_nxt = hdr_cnt + 2'd1;
                    case (hdr_cnt)
                        2'd0: byte_addr_nxt = AW'(rx_data);
                        2'd1: byte_addr_nxt = AW'({rx_data, 8'(byte_addr)});
                        2'd2: len_nxt[7:0]  = rx_data;
                        default: begin
                            len_nxt = hdr_len;
                            if (is_wr) begin
`ifdef UART_MEM_CKSUM_EN
                                // Even an empty write is followed by its checksum byte
                                state_nxt = S_WRITE;
`else
                                if (hdr_len == 16'd0) begin
                                    tx_byte_nxt = ACK;
                                    state_nxt   = S_TX_WAIT;
                                end else begin
                                    state_nxt   = S_WRITE;
                                end
`endif
                            end else if (hdr_len == 16'd0) begin
                                state_nxt = S_IDLE;
                            end else begin
                                // Strobe is issued on entry so read data lands in RD_WAIT
                                state_nxt      = S_RD_REQ;
                                dmem_rd_en_nxt = 1'b1;
                                dmem_addr_nxt  = DMEM_WORD_W'(byte_addr[DMEM_BYTE_ADDR_WIDTH-1:0] >> WB_LOG2);
                            end
                        end
                    endcase
                end
            end

            S_WRITE: begin
                if (rx_ready) begin
`ifdef UART_MEM_CKSUM_EN
                    if (len == 16'd0) begin
                        tx_byte_nxt = (rx_data == sum) ? ACK : NAK;
                        state_nxt   = S_TX_WAIT;
                    end else begin
`else
                    begin
`endif
                        imem_wr_en_nxt   = 1'b1;
                        imem_addr_nxt    = IMEM_WORD_W'(byte_addr[IMEM_BYTE_ADDR_WIDTH-1:0] >> WB_LOG2);
                        imem_byte_en_nxt = WORD_BYTES'(1) << lane;
                        imem_wr_data_nxt = {WORD_BYTES{rx_data}};
                        byte_addr_nxt    = AW'(imem_inc);
                        len_nxt          = len - 16'd1;
`ifdef UART_MEM_CKSUM_EN
                        sum_nxt          = sum + rx_data;
`else
                        if (len == 16'd1) begin
                            tx_byte_nxt = ACK;
                            state_nxt   = S_TX_WAIT;
                        end
`endif
                    end
                end
            end

            S_RD_REQ: state_nxt = S_RD_WAIT;

            S_RD_WAIT: begin
                tx_byte_nxt   = rd_byte;
                rd_active_nxt = 1'b1;
`ifdef UART_MEM_CKSUM_EN
                sum_nxt       = sum + rd_byte;
`endif
                state_nxt     = S_TX_WAIT;
            end

            S_TX_WAIT: begin
                if (tx_empty) begin
                    tx_data_nxt = tx_byte;
                    tx_req_nxt  = 1'b1;
                    state_nxt   = S_TX_HOLD;
                end
            end

            S_TX_HOLD: begin
                // tx_empty may still read 1 this cycle before the transmitter reacts
                state_nxt = S_IDLE;
                if (rd_active) begin
                    byte_addr_nxt = AW'(dmem_inc);
                    len_nxt       = len - 16'd1;
                    if (len != 16'd1) begin
                        state_nxt      = S_RD_REQ;
                        dmem_rd_en_nxt = 1'b1;
                        dmem_addr_nxt  = DMEM_WORD_W'(dmem_inc >> WB_LOG2);
                    end
`ifdef UART_MEM_CKSUM_EN
                    else begin
                        rd_active_nxt = 1'b0;
                        tx_byte_nxt   = sum;
                        state_nxt     = S_TX_WAIT;
                    end
`endif
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb_uart_mem_ctrl: self-checking bench for uart_mem_ctrl (default parameters).
// Frames are sent as bytes; IMEM writes, DMEM read strobes and transmitted
// bytes are collected by a monitor and compared against values derived from
// the frame contents and a bench-side DMEM image.
`timescale 1ns/1ps
module tb_uart_mem_ctrl;
    localparam int unsigned WB  = 4;
    localparam int unsigned IAW = 6;
    localparam int unsigned DAW = 6;
    localparam int unsigned IWW = IAW - 2;
    localparam int unsigned DWW = DAW - 2;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     rx_data;
    logic           rx_ready;
    logic [7:0]     tx_data;
    logic           tx_req;
    logic           tx_empty;
    logic           cpu_rst;
    logic           imem_ctrl;
    logic           imem_wr_en;
    logic [IWW-1:0] imem_addr;
    logic [WB-1:0]  imem_byte_en;
    logic [31:0]    imem_wr_data;
    logic           dmem_ctrl;
    logic           dmem_rd_en;
    logic [DWW-1:0] dmem_addr;
    logic [31:0]    dmem_rd_data;

    logic [31:0]    dmem [0:15];

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]     tx_q[$];
    logic [IWW-1:0] wa_q[$];
    logic [WB-1:0]  wb_q[$];
    logic [31:0]    wd_q[$];
    logic [DWW-1:0] ra_q[$];

    always #5 clk = ~clk;

    uart_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_req       (tx_req),
        .tx_empty     (tx_empty),
        .cpu_rst      (cpu_rst),
        .imem_ctrl    (imem_ctrl),
        .imem_wr_en   (imem_wr_en),
        .imem_addr    (imem_addr),
        .imem_byte_en (imem_byte_en),
        .imem_wr_data (imem_wr_data),
        .dmem_ctrl    (dmem_ctrl),
        .dmem_rd_en   (dmem_rd_en),
        .dmem_addr    (dmem_addr),
        .dmem_rd_data (dmem_rd_data)
    );

    // DMEM: one-cycle read latency
    always @(posedge clk) if (dmem_rd_en) dmem_rd_data <= dmem[dmem_addr];

    // Monitor away from the active edge
    always @(negedge clk) begin
        if (tx_req) tx_q.push_back(tx_data);
        if (imem_wr_en) begin
            wa_q.push_back(imem_addr);
            wb_q.push_back(imem_byte_en);
            wd_q.push_back(imem_wr_data);
        end
        if (dmem_rd_en) ra_q.push_back(dmem_addr);
    end

    task automatic clear_q();
        tx_q.delete(); wa_q.delete(); wb_q.delete(); wd_q.delete(); ra_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, output bit ok);
        int cyc = 0;
        while (tx_q.size() < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        ok = (tx_q.size() >= n);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] pl[$], input string tag);
        int n;
        int a;
        bit ok;
        logic [IWW-1:0] exp_w;
        logic [WB-1:0]  exp_be;
        logic [31:0]    exp_d;
        n = pl.size();
        clear_q();
        send_byte(8'h01);
        send_byte(addr[7:0]);
        send_byte(addr[15:8]);
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        foreach (pl[i]) send_byte(pl[i]);
`ifdef UART_MEM_CKSUM_EN
        begin
            logic [7:0] s;
            s = 8'h00;
            foreach (pl[i]) s = s + pl[i];
            send_byte(s);
        end
`endif
        wait_tx(1, ok);
        idle(4);
        n_cmp++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== ACK) begin
            n_err++;
            $display("FAIL %s ack: got %0d bytes first=%h, want 1 byte %h",
                     tag, tx_q.size(), ok ? tx_q[0] : 8'hxx, ACK);
        end
        n_cmp++;
        if (wa_q.size() != n) begin
            n_err++;
            $display("FAIL %s wr_count: got %0d, want %0d", tag, wa_q.size(), n);
        end
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            a      = (int'(addr) + i) % (1 << IAW);
            exp_w  = IWW'(a / WB);
            exp_be = WB'(1 << (a % WB));
            exp_d  = {WB{pl[i]}};
            n_cmp++;
            if (wa_q[i] !== exp_w || wb_q[i] !== exp_be || wd_q[i] !== exp_d) begin
                n_err++;
                $display("FAIL %s wr[%0d]: got addr=%0d be=%b data=%h, want addr=%0d be=%b data=%h",
                         tag, i, wa_q[i], wb_q[i], wd_q[i], exp_w, exp_be, exp_d);
            end
        end
    endtask

    task automatic do_read(input logic [15:0] addr, input int len, input string tag);
        logic [7:0] exp_q[$];
        int a;
        bit ok;
        clear_q();
        for (int i = 0; i < len; i++) begin
            a = (int'(addr) + i) % (1 << DAW);
            exp_q.push_back(8'(dmem[a / WB] >> (8 * (a % WB))));
        end
`ifdef UART_MEM_CKSUM_EN
        begin
            logic [7:0] s;
            s = 8'h00;
            foreach (exp_q[i]) s = s + exp_q[i];
            exp_q.push_back(s);
        end
`endif
        send_byte(8'h02);
        send_byte(addr[7:0]);
        send_byte(addr[15:8]);
        send_byte(8'(len));
        send_byte(8'(len >> 8));
        wait_tx(exp_q.size(), ok);
        idle(20);
        n_cmp++;
        if (tx_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s tx_count: got %0d, want %0d", tag, tx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            n_cmp++;
            if (tx_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s tx[%0d]: got %h, want %h", tag, i, tx_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (ra_q.size() != len) begin
            n_err++;
            $display("FAIL %s rd_count: got %0d, want %0d", tag, ra_q.size(), len);
        end
        for (int i = 0; i < len && i < ra_q.size(); i++) begin
            a = (int'(addr) + i) % (1 << DAW);
            n_cmp++;
            if (ra_q[i] !== DWW'(a / WB)) begin
                n_err++;
                $display("FAIL %s rd_addr[%0d]: got %0d, want %0d", tag, i, ra_q[i], a / WB);
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        tx_empty = 1'b1;
        for (int i = 0; i < 16; i++) dmem[i] = $urandom;
        idle(3);
        n_cmp++;
        if ({cpu_rst, imem_ctrl, dmem_ctrl} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, want 111", {cpu_rst, imem_ctrl, dmem_ctrl});
        end
        n_cmp++;
        if ({tx_req, imem_wr_en, dmem_rd_en} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_strobes: got %b, want 000", {tx_req, imem_wr_en, dmem_rd_en});
        end
        n_cmp++;
        if (tx_data !== 8'h00 || imem_addr !== '0 || dmem_addr !== '0) begin
            n_err++;
            $display("FAIL reset_data: got tx=%h ia=%0d da=%0d, want 0 0 0", tx_data, imem_addr, dmem_addr);
        end
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_write_basic();
        logic [7:0] pl[$];
        pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_write(16'h0004, pl, "write_basic");
    endtask

    task automatic test_read_basic();
        dmem[1] = 32'h44332211;
        do_read(16'h0005, 2, "read_basic");
    endtask

    task automatic test_run_halt();
        bit ok;
        logic [7:0] cmds [2];
        cmds[0] = 8'h01;
        cmds[1] = 8'h02;
        clear_q();
        send_byte(8'h03);
        wait_tx(1, ok);
        idle(4);
        n_cmp++;
        if (!ok || tx_q[0] !== ACK) begin
            n_err++;
            $display("FAIL run_ack: got %h, want %h", ok ? tx_q[0] : 8'hxx, ACK);
        end
        n_cmp++;
        if ({cpu_rst, imem_ctrl, dmem_ctrl} !== 3'b000) begin
            n_err++;
            $display("FAIL run_ctrl: got %b, want 000", {cpu_rst, imem_ctrl, dmem_ctrl});
        end
        // Memory frames while running: one NAK, trailing bytes dropped while it waits
        foreach (cmds[k]) begin
            clear_q();
            tx_empty = 1'b0;
            send_byte(cmds[k]);
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h01);
            send_byte(8'h00);
            idle(5);
            tx_empty = 1'b1;
            wait_tx(1, ok);
            idle(10);
            n_cmp++;
            if (tx_q.size() != 1 || tx_q[0] !== NAK) begin
                n_err++;
                $display("FAIL running_nak cmd=%h: got %0d bytes first=%h, want 1 byte %h",
                         cmds[k], tx_q.size(), ok ? tx_q[0] : 8'hxx, NAK);
            end
            n_cmp++;
            if (wa_q.size() != 0 || ra_q.size() != 0) begin
                n_err++;
                $display("FAIL running_noaccess cmd=%h: got wr=%0d rd=%0d, want 0 0",
                         cmds[k], wa_q.size(), ra_q.size());
            end
        end
        clear_q();
        send_byte(8'h04);
        wait_tx(1, ok);
        idle(4);
        n_cmp++;
        if (!ok || tx_q[0] !== ACK) begin
            n_err++;
            $display("FAIL halt_ack: got %h, want %h", ok ? tx_q[0] : 8'hxx, ACK);
        end
        n_cmp++;
        if ({cpu_rst, imem_ctrl, dmem_ctrl} !== 3'b111) begin
            n_err++;
            $display("FAIL halt_ctrl: got %b, want 111", {cpu_rst, imem_ctrl, dmem_ctrl});
        end
    endtask

    task automatic test_wrap();
        logic [7:0] pl[$];
        pl = '{8'h11, 8'h22};
        do_write(16'h003F, pl, "write_wrap");
        do_read(16'h003E, 4, "read_wrap");
    endtask

    task automatic test_random();
        logic [7:0] pl[$];
        for (int it = 0; it < 6; it++) begin
            pl.delete();
            repeat ($urandom_range(1, 9)) pl.push_back(8'($urandom));
            do_write(16'($urandom), pl, $sformatf("write_rand%0d", it));
        end
        for (int i = 0; i < 16; i++) dmem[i] = $urandom;
        for (int it = 0; it < 6; it++) begin
            do_read(16'($urandom), $urandom_range(1, 7), $sformatf("read_rand%0d", it));
        end
    endtask

    task automatic test_tx_hold();
        bit ok;
        int a;
        int exp_n;
        logic [7:0] exp_b;
        logic [15:0] addr;
        addr  = 16'($urandom);
        a     = int'(addr) % (1 << DAW);
        exp_b = 8'(dmem[a / WB] >> (8 * (a % WB)));
`ifdef UART_MEM_CKSUM_EN
        exp_n = 2;
`else
        exp_n = 1;
`endif
        clear_q();
        tx_empty = 1'b0;
        send_byte(8'h02);
        send_byte(addr[7:0]);
        send_byte(addr[15:8]);
        send_byte(8'h01);
        send_byte(8'h00);
        idle(50);
        n_cmp++;
        if (tx_q.size() != 0) begin
            n_err++;
            $display("FAIL hold_blocked: got %0d tx_req pulses, want 0", tx_q.size());
        end
        tx_empty = 1'b1;
        wait_tx(1, ok);
        idle(20);
        n_cmp++;
        if (tx_q.size() != exp_n) begin
            n_err++;
            $display("FAIL hold_count: got %0d, want %0d", tx_q.size(), exp_n);
        end
        n_cmp++;
        if (!ok || tx_q[0] !== exp_b) begin
            n_err++;
            $display("FAIL hold_data: got %h, want %h", ok ? tx_q[0] : 8'hxx, exp_b);
        end
        clear_q();
        send_byte(8'h7F);
        wait_tx(1, ok);
        idle(4);
        n_cmp++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== NAK) begin
            n_err++;
            $display("FAIL unknown_nak: got %h, want %h", ok ? tx_q[0] : 8'hxx, NAK);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pl[$];
        clear_q();
        send_byte(8'h01);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        idle(2);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({cpu_rst, imem_ctrl, dmem_ctrl, tx_req, imem_wr_en, dmem_rd_en} !== 6'b111000) begin
            n_err++;
            $display("FAIL midrst_ctrl: got %b, want 111000",
                     {cpu_rst, imem_ctrl, dmem_ctrl, tx_req, imem_wr_en, dmem_rd_en});
        end
        n_cmp++;
        if (tx_data !== 8'h00 || imem_addr !== '0 || imem_byte_en !== '0 || dmem_addr !== '0) begin
            n_err++;
            $display("FAIL midrst_data: got tx=%h ia=%0d be=%b da=%0d, want zeros",
                     tx_data, imem_addr, imem_byte_en, dmem_addr);
        end
        n_cmp++;
        if (wa_q.size() != 2) begin
            n_err++;
            $display("FAIL midrst_partial: got %0d writes, want 2", wa_q.size());
        end
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        repeat (4) pl.push_back(8'($urandom));
        do_write(16'($urandom), pl, "write_after_reset");
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_run_halt();
        test_wrap();
        test_random();
        test_tx_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, compared=%0d mismatched=%0d", n_cmp, n_err);
        $fatal(1);
    end

endmodule
